// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings for the memory read-channel arbiter
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    REQ  = 3'b010,
    RSP  = 3'b100
  } state_e;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } req_id_e;

  localparam int BEAT_CNT_WIDTH = 4;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin selector, history updated on load
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    req_icache,
  input  logic    req_dcache,
  input  logic    load,
  output req_id_e grant
);

  req_id_e last_grant;

  // On a tie the requester that was not served last time wins.
  always_comb begin
    grant = ICACHE;
    if (req_icache && req_dcache) begin
      grant = (last_grant == ICACHE) ? DCACHE : ICACHE;
    end else if (req_dcache) begin
      grant = DCACHE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= DCACHE;
    end else if (load) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/mem_rd_arbiter.sv
// rtl/mem_rd_arbiter.sv - shares one memory read channel between I-cache and D-cache
module mem_rd_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      from_icache_rd_req_valid,
  input  logic [ADDR_WIDTH-1:0]     from_icache_rd_req_addr,
  output logic                      to_icache_rd_req_ready,
  output logic                      to_icache_rd_rsp_valid,
  output logic [DATA_WIDTH-1:0]     to_icache_rd_rsp_data,
  output logic                      to_icache_rd_rsp_last,
  input  logic                      from_icache_rd_rsp_ready,
  input  logic                      from_dcache_rd_req_valid,
  input  logic [ADDR_WIDTH-1:0]     from_dcache_rd_req_addr,
  output logic                      to_dcache_rd_req_ready,
  output logic                      to_dcache_rd_rsp_valid,
  output logic [DATA_WIDTH-1:0]     to_dcache_rd_rsp_data,
  output logic                      to_dcache_rd_rsp_last,
  input  logic                      from_dcache_rd_rsp_ready,
  output logic                      to_mem_rd_req_valid,
  output logic [ADDR_WIDTH-1:0]     to_mem_rd_req_addr,
  input  logic                      from_mem_rd_req_ready,
  input  logic                      from_mem_rd_rsp_valid,
  input  logic [DATA_WIDTH-1:0]     from_mem_rd_rsp_data,
  input  logic                      from_mem_rd_rsp_last,
  output logic                      to_mem_rd_rsp_ready,
  output logic                      busy,
  output logic [BEAT_CNT_WIDTH-1:0] beat_cnt
);

  state_e                    state;
  state_e                    state_nxt;
  req_id_e                   grant_id;
  req_id_e                   arb_grant;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [BEAT_CNT_WIDTH-1:0] beat_cnt_q;
  logic                      any_req;
  logic                      grant_load;
  logic                      beat_acc;

  assign any_req    = from_icache_rd_req_valid | from_dcache_rd_req_valid;
  assign grant_load = (state == IDLE) && any_req;
  assign beat_acc   = (state == RSP) && from_mem_rd_rsp_valid && to_mem_rd_rsp_ready;

  rr_arb2 u_rr_arb2 (
    .clk        (clk),
    .rst        (rst),
    .req_icache (from_icache_rd_req_valid),
    .req_dcache (from_dcache_rd_req_valid),
    .load       (grant_load),
    .grant      (arb_grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = REQ;
      REQ:     if (from_mem_rd_req_ready) state_nxt = RSP;
      RSP:     if (beat_acc && from_mem_rd_rsp_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address is captured at grant time so a requester may drop valid while in REQ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_id   <= ICACHE;
      addr_q     <= '0;
      beat_cnt_q <= '0;
    end else begin
      if (grant_load) begin
        grant_id <= arb_grant;
        addr_q   <= (arb_grant == ICACHE) ? from_icache_rd_req_addr : from_dcache_rd_req_addr;
      end
      if ((state == REQ) && from_mem_rd_req_ready) begin
        beat_cnt_q <= '0;
      end else if (beat_acc) begin
        beat_cnt_q <= beat_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    to_mem_rd_req_valid    = 1'b0;
    to_mem_rd_req_addr     = '0;
    to_mem_rd_rsp_ready    = 1'b0;
    to_icache_rd_req_ready = 1'b0;
    to_icache_rd_rsp_valid = 1'b0;
    to_icache_rd_rsp_data  = '0;
    to_icache_rd_rsp_last  = 1'b0;
    to_dcache_rd_req_ready = 1'b0;
    to_dcache_rd_rsp_valid = 1'b0;
    to_dcache_rd_rsp_data  = '0;
    to_dcache_rd_rsp_last  = 1'b0;
    busy                   = (state != IDLE);
    beat_cnt               = beat_cnt_q;
    unique case (state)
      REQ: begin
        to_mem_rd_req_valid = 1'b1;
        to_mem_rd_req_addr  = addr_q;
        if (grant_id == ICACHE) begin
          to_icache_rd_req_ready = from_mem_rd_req_ready;
        end else begin
          to_dcache_rd_req_ready = from_mem_rd_req_ready;
        end
      end
      // Beats pass straight through; the granted cache owns the back-pressure.
      RSP: begin
        if (grant_id == ICACHE) begin
          to_icache_rd_rsp_valid = from_mem_rd_rsp_valid;
          to_icache_rd_rsp_data  = from_mem_rd_rsp_data;
          to_icache_rd_rsp_last  = from_mem_rd_rsp_last;
          to_mem_rd_rsp_ready    = from_icache_rd_rsp_ready;
        end else begin
          to_dcache_rd_rsp_valid = from_mem_rd_rsp_valid;
          to_dcache_rd_rsp_data  = from_mem_rd_rsp_data;
          to_dcache_rd_rsp_last  = from_mem_rd_rsp_last;
          to_mem_rd_rsp_ready    = from_dcache_rd_rsp_ready;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// tb/tb_mem_rd_arbiter.sv - self-checking bench for mem_rd_arbiter
module tb_mem_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv, dv, irdy, drdy, mq_rdy, mr_v, mr_l;
  logic [31:0] ia, da, mr_d;
  logic        i_qrdy, i_v, i_l, d_qrdy, d_v, d_l, mq_v, mr_rdy, busy;
  logic [31:0] i_d, d_d, mq_a;
  logic [3:0]  bc;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: who owns the channel, whether the address went out, beats taken.
  bit          m_active, m_addr_sent;
  int          m_owner, m_last, m_beats;
  logic [31:0] m_addr;

  typedef struct {
    logic        iv;
    logic [31:0] ia;
    logic        mq_rdy;
    logic        mr_v;
    logic [31:0] mr_d;
    logic        mr_l;
    logic        irdy;
    logic        e_busy;
    logic        e_mq_v;
    logic [31:0] e_mq_a;
    logic        e_i_qrdy;
    logic        e_i_v;
    logic [31:0] e_i_d;
    logic        e_i_l;
    logic        e_mr_rdy;
    logic [3:0]  e_bc;
  } vec_t;

  vec_t tbl[12];

  mem_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .from_icache_rd_req_valid (iv),
    .from_icache_rd_req_addr  (ia),
    .to_icache_rd_req_ready   (i_qrdy),
    .to_icache_rd_rsp_valid   (i_v),
    .to_icache_rd_rsp_data    (i_d),
    .to_icache_rd_rsp_last    (i_l),
    .from_icache_rd_rsp_ready (irdy),
    .from_dcache_rd_req_valid (dv),
    .from_dcache_rd_req_addr  (da),
    .to_dcache_rd_req_ready   (d_qrdy),
    .to_dcache_rd_rsp_valid   (d_v),
    .to_dcache_rd_rsp_data    (d_d),
    .to_dcache_rd_rsp_last    (d_l),
    .from_dcache_rd_rsp_ready (drdy),
    .to_mem_rd_req_valid      (mq_v),
    .to_mem_rd_req_addr       (mq_a),
    .from_mem_rd_req_ready    (mq_rdy),
    .from_mem_rd_rsp_valid    (mr_v),
    .from_mem_rd_rsp_data     (mr_d),
    .from_mem_rd_rsp_last     (mr_l),
    .to_mem_rd_rsp_ready      (mr_rdy),
    .busy                     (busy),
    .beat_cnt                 (bc)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active    = 1'b0;
    m_addr_sent = 1'b0;
    m_owner     = 0;
    m_last      = 1;
    m_beats     = 0;
    m_addr      = '0;
  endtask

  task automatic check_model();
    bit a_ph, d_ph, i_sel, d_sel;
    a_ph  = m_active && !m_addr_sent;
    d_ph  = m_active && m_addr_sent;
    i_sel = d_ph && (m_owner == 0);
    d_sel = d_ph && (m_owner == 1);
    chk("m_busy", busy, m_active);
    chk("m_mem_req_valid", mq_v, a_ph);
    chk("m_mem_req_addr", mq_a, a_ph ? m_addr : 32'h0);
    chk("m_i_req_ready", i_qrdy, a_ph && (m_owner == 0) && mq_rdy);
    chk("m_d_req_ready", d_qrdy, a_ph && (m_owner == 1) && mq_rdy);
    chk("m_i_rsp_valid", i_v, i_sel && mr_v);
    chk("m_i_rsp_data", i_d, i_sel ? mr_d : 32'h0);
    chk("m_i_rsp_last", i_l, i_sel && mr_l);
    chk("m_d_rsp_valid", d_v, d_sel && mr_v);
    chk("m_d_rsp_data", d_d, d_sel ? mr_d : 32'h0);
    chk("m_d_rsp_last", d_l, d_sel && mr_l);
    chk("m_mem_rsp_ready", mr_rdy, d_ph && ((m_owner == 0) ? irdy : drdy));
    chk("m_beat_cnt", bc, m_beats % 16);
  endtask

  task automatic model_update();
    if (!m_active) begin
      if (iv || dv) begin
        if (iv && dv) m_owner = (m_last == 1) ? 0 : 1;
        else          m_owner = iv ? 0 : 1;
        m_last      = m_owner;
        m_addr      = (m_owner == 0) ? ia : da;
        m_active    = 1'b1;
        m_addr_sent = 1'b0;
      end
    end else if (!m_addr_sent) begin
      if (mq_rdy) begin
        m_addr_sent = 1'b1;
        m_beats     = 0;
      end
    end else if (mr_v && ((m_owner == 0) ? irdy : drdy)) begin
      m_beats = (m_beats + 1) % 16;
      if (mr_l) m_active = 1'b0;
    end
  endtask

  // Called at the falling edge; returns 1 time unit after the next rising edge.
  task automatic sample_and_advance();
    check_model();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic tick();
    #4;
    sample_and_advance();
  endtask

  task automatic idle_inputs();
    iv = 1'b0; ia = '0; dv = 1'b0; da = '0;
    irdy = 1'b0; drdy = 1'b0; mq_rdy = 1'b0;
    mr_v = 1'b0; mr_d = '0; mr_l = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_beats(input int n, input logic [31:0] base);
    irdy = 1'b1; drdy = 1'b1; mr_v = 1'b1;
    for (int k = 0; k < n; k++) begin
      mr_d = base + k;
      mr_l = (k == n - 1);
      tick();
    end
    idle_inputs();
  endtask

  task automatic drain();
    iv = 1'b0; dv = 1'b0; mq_rdy = 1'b1; mr_v = 1'b1; mr_l = 1'b1;
    irdy = 1'b1; drdy = 1'b1;
    for (int c = 0; c < 10 && busy; c++) tick();
    chk("drain_idle", busy, 1'b0);
    idle_inputs();
  endtask

  initial begin
    logic [5:0] seq;
    int         ng;
    bit         k_last, acc, d_taken;

    // Single I-cache burst; valid drops in REQ and the address input changes.
    tbl[0] = '{1'b1, 32'h1020, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0,
               1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0};
    tbl[1] = '{1'b0, 32'h5f00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0,
               1'b1, 1'b1, 32'h1020, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0};
    tbl[2] = '{1'b0, 32'h5f00, 1'b1, 1'b1, 32'h99, 1'b0, 1'b1,
               1'b1, 1'b1, 32'h1020, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0};
    for (int k = 0; k < 8; k++) begin
      tbl[3+k] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h11 + k, (k == 7), 1'b1,
                   1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h11 + k, (k == 7), 1'b1, 4'(k)};
    end
    tbl[11] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0,
                1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'd8};

    // Reset with live-looking inputs: outputs must all stay at zero.
    rst = 1'b1;
    idle_inputs();
    iv = 1'b1; ia = 32'h40; mr_v = 1'b1; mr_d = 32'habc; mq_rdy = 1'b1; irdy = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model();
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    idle_inputs();

    for (int r = 0; r < 12; r++) begin
      iv = tbl[r].iv; ia = tbl[r].ia; mq_rdy = tbl[r].mq_rdy;
      mr_v = tbl[r].mr_v; mr_d = tbl[r].mr_d; mr_l = tbl[r].mr_l; irdy = tbl[r].irdy;
      #4;
      chk($sformatf("t%0d_busy", r), busy, tbl[r].e_busy);
      chk($sformatf("t%0d_mem_req_valid", r), mq_v, tbl[r].e_mq_v);
      chk($sformatf("t%0d_mem_req_addr", r), mq_a, tbl[r].e_mq_a);
      chk($sformatf("t%0d_i_req_ready", r), i_qrdy, tbl[r].e_i_qrdy);
      chk($sformatf("t%0d_i_rsp_valid", r), i_v, tbl[r].e_i_v);
      chk($sformatf("t%0d_i_rsp_data", r), i_d, tbl[r].e_i_d);
      chk($sformatf("t%0d_i_rsp_last", r), i_l, tbl[r].e_i_l);
      chk($sformatf("t%0d_mem_rsp_ready", r), mr_rdy, tbl[r].e_mr_rdy);
      chk($sformatf("t%0d_beat_cnt", r), bc, tbl[r].e_bc);
      sample_and_advance();
    end

    // Tie after reset: I-cache first, D-cache after one IDLE cycle, with back-pressure.
    do_reset();
    iv = 1'b1; ia = 32'h2000; dv = 1'b1; da = 32'h3040;
    tick();
    mq_rdy = 1'b1;
    #4;
    chk("tie_first_addr", mq_a, 32'h2000);
    chk("tie_first_i_ready", i_qrdy, 1'b1);
    sample_and_advance();
    iv = 1'b0; mq_rdy = 1'b0;
    run_beats(4, 32'h100);
    dv = 1'b1; da = 32'h3040;
    #4;
    chk("gap_idle_busy", busy, 1'b0);
    sample_and_advance();
    mq_rdy = 1'b1;
    #4;
    chk("tie_second_addr", mq_a, 32'h3040);
    chk("tie_second_d_ready", d_qrdy, 1'b1);
    sample_and_advance();
    dv = 1'b0; mq_rdy = 1'b0; mr_v = 1'b1; drdy = 1'b1; mr_l = 1'b0;
    mr_d = 32'h200; tick();
    mr_d = 32'h201; tick();
    drdy = 1'b0; mr_d = 32'h202;
    for (int c = 0; c < 3; c++) begin
      #4;
      chk("bp_mem_rsp_ready", mr_rdy, 1'b0);
      chk("bp_beat_cnt", bc, 4'd2);
      chk("bp_data_held", d_d, 32'h202);
      sample_and_advance();
    end
    drdy = 1'b1; tick();
    mr_d = 32'h203; mr_l = 1'b1;
    #4;
    chk("bp_last_beat", d_l, 1'b1);
    sample_and_advance();
    idle_inputs();
    #4;
    chk("bp_final_cnt", bc, 4'd4);
    sample_and_advance();

    // I-cache requests continuously, D-cache once: grants must go I, D, I.
    iv = 1'b1; ia = 32'h4000; dv = 1'b1; da = 32'h5000;
    mq_rdy = 1'b1; mr_v = 1'b1; irdy = 1'b1; drdy = 1'b1;
    seq = '0; ng = 0; k_last = 1'b0; d_taken = 1'b0;
    for (int c = 0; c < 60 && ng < 3; c++) begin
      mr_l = k_last;
      mr_d = $urandom;
      #4;
      if (i_qrdy) begin seq = {seq[3:0], 2'd1}; ng++; end
      if (d_qrdy) begin seq = {seq[3:0], 2'd2}; ng++; d_taken = 1'b1; end
      acc = mr_rdy && mr_v;
      sample_and_advance();
      if (acc) k_last = ~k_last;
      if (d_taken) dv = 1'b0;
    end
    chk("rr_alternation", seq, 6'b01_10_01);
    drain();

    // Reset at beat 4 of an I-cache burst; next tie must go to the I-cache again.
    iv = 1'b1; ia = 32'h6000;
    tick();
    mq_rdy = 1'b1; tick();
    iv = 1'b0; mq_rdy = 1'b0; mr_v = 1'b1; irdy = 1'b1; mr_l = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mr_d = 32'h600 + k;
      tick();
    end
    chk("beat4_before_rst", bc, 4'd4);
    mr_d = 32'h604;
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_beat_cnt", bc, 4'd0);
    chk("rst_mid_i_rsp_valid", i_v, 1'b0);
    chk("rst_mid_i_rsp_data", i_d, 32'h0);
    chk("rst_mid_mem_rsp_ready", mr_rdy, 1'b0);
    chk("rst_mid_mem_req_valid", mq_v, 1'b0);
    model_reset();
    #1;
    rst = 1'b0;
    idle_inputs();
    iv = 1'b1; ia = 32'h7000; dv = 1'b1; da = 32'h8000;
    #2;
    sample_and_advance();
    mq_rdy = 1'b1;
    #4;
    chk("rst_then_i_first", mq_a, 32'h7000);
    sample_and_advance();
    drain();

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      iv     = ($urandom_range(0, 2) != 0);
      ia     = $urandom & ~32'h1f;
      dv     = ($urandom_range(0, 2) != 0);
      da     = $urandom & ~32'h1f;
      irdy   = ($urandom_range(0, 3) != 0);
      drdy   = ($urandom_range(0, 3) != 0);
      mq_rdy = ($urandom_range(0, 2) == 0);
      mr_v   = ($urandom_range(0, 1) != 0);
      mr_d   = $urandom;
      mr_l   = ($urandom_range(0, 5) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
